// File: rtl/hwpe_ctrl_offloader.sv
// rtl/hwpe_ctrl_offloader.sv - peripheral-bus master that offloads one job to an HWPE
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   job_valid_i/job_ready_o   descriptor handshake (ready only while idle)
//   job_params_i, job_wait_i  IO register words and poll-until-done flag
//   busy_o, job_id_o          activity flag and context id granted by the acquire
//   job_started_o/done/error  single-cycle job event pulses
//   retries_o                 acquire retries used by the current/last job
//   req_o..data_o, gnt_i      peripheral request channel
//   r_valid_i, r_data_i       peripheral response channel
module hwpe_ctrl_offloader #(
  parameter int unsigned N_IO_REGS      = 2,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] TRIGGER_OFS    = 32'h00,
  parameter logic [31:0] ACQUIRE_OFS    = 32'h04,
  parameter logic [31:0] STATUS_OFS     = 32'h0C,
  parameter logic [31:0] IO_OFS         = 32'h40,
  parameter int unsigned BACKOFF_CYCLES = 8,
  parameter int unsigned MAX_RETRY      = 15,
  parameter int unsigned POLL_INTERVAL  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    job_valid_i,
  output logic                    job_ready_o,
  input  logic [N_IO_REGS*32-1:0] job_params_i,
  input  logic                    job_wait_i,
  output logic                    busy_o,
  output logic [7:0]              job_id_o,
  output logic                    job_started_o,
  output logic                    job_done_o,
  output logic                    job_error_o,
  output logic [3:0]              retries_o,
  output logic                    req_o,
  input  logic                    gnt_i,
  output logic [31:0]             add_o,
  output logic                    wen_o,
  output logic [3:0]              be_o,
  output logic [31:0]             data_o,
  input  logic                    r_valid_i,
  input  logic [31:0]             r_data_i
);

  localparam int unsigned KW = $clog2(N_IO_REGS + 1);
  localparam int unsigned CW = 16;
  localparam int unsigned RW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_ACQ, S_WR, S_TRIG, S_POLL_WAIT, S_POLL, S_BACKOFF
  } state_e;

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic                    pend_q, pend_d;
  logic [31:0]             add_q, add_d;
  logic                    wen_q, wen_d;
  logic [31:0]             data_q, data_d;
  logic [N_IO_REGS*32-1:0] params_q, params_d;
  logic                    wait_q, wait_d;
  logic [KW-1:0]           k_q, k_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [7:0]              job_id_q, job_id_d;

  logic                    resp;
  logic [KW-1:0]           k_nxt;
  logic [7:0]              status_byte;

  // A response only counts while a granted transaction is outstanding.
  assign resp = pend_q & r_valid_i;

  // Status packs one byte per context; only ours decides completion.
  assign status_byte = r_data_i[{job_id_q[1:0], 3'b000} +: 8];

  assign job_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign job_id_o    = job_id_q;
  assign retries_o   = (retry_q > RW'(15)) ? 4'hF : retry_q[3:0];
  assign req_o       = req_q;
  assign add_o       = add_q;
  assign wen_o       = wen_q;
  assign be_o        = 4'hF;
  assign data_o      = data_q;

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    pend_d        = pend_q;
    add_d         = add_q;
    wen_d         = wen_q;
    data_d        = data_q;
    params_d      = params_q;
    wait_d        = wait_q;
    k_d           = k_q;
    cnt_d         = cnt_q;
    retry_d       = retry_q;
    job_id_d      = job_id_q;
    k_nxt         = k_q + 1'b1;
    job_started_o = 1'b0;
    job_done_o    = 1'b0;
    job_error_o   = 1'b0;

    // Request fields stay frozen until the grant; then drop req and wait.
    if (req_q && gnt_i) begin
      req_d  = 1'b0;
      pend_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (job_valid_i) begin
          params_d = job_params_i;
          wait_d   = job_wait_i;
          retry_d  = '0;
          state_d  = S_ACQ;
          req_d    = 1'b1;
          add_d    = BASE_ADDR + ACQUIRE_OFS;
          wen_d    = 1'b1;
          data_d   = '0;
        end
      end

      S_ACQ: begin
        if (resp) begin
          pend_d = 1'b0;
          if (!r_data_i[31]) begin
            job_id_d = r_data_i[7:0];
            k_d      = '0;
            state_d  = S_WR;
            req_d    = 1'b1;
            add_d    = BASE_ADDR + IO_OFS;
            wen_d    = 1'b0;
            data_d   = params_q[31:0];
          end else begin
            // Every negative code (busy contexts, other PE offloading) backs off.
            state_d = S_BACKOFF;
            cnt_d   = '0;
          end
        end
      end

      S_WR: begin
        if (resp) begin
          pend_d = 1'b0;
          req_d  = 1'b1;
          wen_d  = 1'b0;
          if (k_q == KW'(N_IO_REGS - 1)) begin
            k_d     = KW'(N_IO_REGS);
            state_d = S_TRIG;
            add_d   = BASE_ADDR + TRIGGER_OFS;
            data_d  = '0;
          end else begin
            k_d    = k_nxt;
            add_d  = BASE_ADDR + IO_OFS + (32'(k_nxt) << 2);
            data_d = params_q[32*k_nxt +: 32];
          end
        end
      end

      S_TRIG: begin
        if (resp) begin
          pend_d        = 1'b0;
          job_started_o = 1'b1;
          if (!wait_q) begin
            job_done_o = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_POLL_WAIT;
            cnt_d   = '0;
          end
        end
      end

      S_POLL_WAIT: begin
        if (cnt_q == CW'(POLL_INTERVAL - 1)) begin
          state_d = S_POLL;
          req_d   = 1'b1;
          add_d   = BASE_ADDR + STATUS_OFS;
          wen_d   = 1'b1;
          data_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_POLL: begin
        if (resp) begin
          pend_d = 1'b0;
          if (status_byte == 8'h00) begin
            job_done_o = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_POLL_WAIT;
            cnt_d   = '0;
          end
        end
      end

      S_BACKOFF: begin
        // The exhaustion decision is made on the first backoff cycle only.
        if ((cnt_q == '0) && (MAX_RETRY != 0) && (retry_q == RW'(MAX_RETRY))) begin
          job_error_o = 1'b1;
          job_done_o  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          if ((cnt_q == '0) && (retry_q != '1)) begin
            retry_d = retry_q + 1'b1;
          end
          if (cnt_q == CW'(BACKOFF_CYCLES - 1)) begin
            state_d = S_ACQ;
            req_d   = 1'b1;
            add_d   = BASE_ADDR + ACQUIRE_OFS;
            wen_d   = 1'b1;
            data_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      pend_q   <= 1'b0;
      add_q    <= '0;
      wen_q    <= 1'b1;
      data_q   <= '0;
      params_q <= '0;
      wait_q   <= 1'b0;
      k_q      <= '0;
      cnt_q    <= '0;
      retry_q  <= '0;
      job_id_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      pend_q   <= pend_d;
      add_q    <= add_d;
      wen_q    <= wen_d;
      data_q   <= data_d;
      params_q <= params_d;
      wait_q   <= wait_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      job_id_q <= job_id_d;
    end
  end

endmodule
